// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// state encoding, field widths and byte-lane helpers.
package dcache_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INDEX_W = 3;
  localparam int OFFSET_W    = 2;
  localparam int BLOCK_W     = 32;
  localparam int DEF_TAG_W   = DEF_ADDR_W - DEF_INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_e;

  function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0]  blk,
                                          input logic [OFFSET_W-1:0] off);
    return blk[{off, 3'b000} +: 8];
  endfunction

  function automatic logic [BLOCK_W-1:0] put_byte(input logic [BLOCK_W-1:0]  blk,
                                                  input logic [OFFSET_W-1:0] off,
                                                  input logic [7:0]          val);
    logic [BLOCK_W-1:0] res;
    res = blk;
    res[{off, 3'b000} +: 8] = val;
    return res;
  endfunction

endpackage

// File: rtl/dcache_fsm.sv
// Miss-handling controller: sequences victim write-back and block fetch,
// and decodes the memory request lines and the CPU stall from the state.
module dcache_fsm
  import dcache_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req,
  input  logic   hit,
  input  logic   victim_dirty,
  input  logic   mem_busywait,
  output state_e state,
  output logic   busywait,
  output logic   mem_read,
  output logic   mem_write,
  output logic   fill_en
);

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busywait  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    fill_en   = 1'b0;
    case (state_q)
      IDLE: begin
        busywait = req && !hit;
        if (req && !hit) state_d = victim_dirty ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        mem_write = 1'b1;
        busywait  = 1'b1;
        if (!mem_busywait) state_d = FETCH;
      end
      FETCH: begin
        mem_read = 1'b1;
        busywait = 1'b1;
        if (!mem_busywait) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The stall must vanish the moment reset is raised, even with a request held.
    if (rst) busywait = 1'b0;
  end

  assign state = state_q;

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate byte data cache between the CPU
// data port and a 32-bit-block main memory; holds tag/data arrays and hit logic.
module dcache
  import dcache_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       READ,
  input  logic                       WRITE,
  input  logic [ADDR_W-1:0]          ADDRESS,
  input  logic [7:0]                 WRITEDATA,
  output logic [7:0]                 READDATA,
  output logic                       BUSYWAIT,
  output logic                       MEM_READ,
  output logic                       MEM_WRITE,
  output logic [ADDR_W-OFFSET_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]         MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]         MEM_READDATA,
  input  logic                       MEM_BUSYWAIT
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS  = 1 << INDEX_W;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  index;
  logic [OFFSET_W-1:0] offset;

  logic [SETS-1:0]     valid_q, valid_d;
  logic [SETS-1:0]     dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [TAG_W-1:0]    tag_d  [SETS];
  logic [BLOCK_W-1:0]  data_q [SETS];
  logic [BLOCK_W-1:0]  data_d [SETS];

  state_e state;
  logic   hit, victim_dirty, fill_en, write_en;

  assign req_tag = ADDRESS[ADDR_W-1 -: TAG_W];
  assign index   = ADDRESS[OFFSET_W +: INDEX_W];
  assign offset  = ADDRESS[OFFSET_W-1:0];

  assign hit          = valid_q[index] && (tag_q[index] == req_tag);
  assign victim_dirty = valid_q[index] && dirty_q[index];
  assign write_en     = (state == IDLE) && WRITE && hit;

  dcache_fsm u_fsm (
    .clk          (CLK),
    .rst          (RESET),
    .req          (READ || WRITE),
    .hit          (hit),
    .victim_dirty (victim_dirty),
    .mem_busywait (MEM_BUSYWAIT),
    .state        (state),
    .busywait     (BUSYWAIT),
    .mem_read     (MEM_READ),
    .mem_write    (MEM_WRITE),
    .fill_en      (fill_en)
  );

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[index] = 1'b1;
      dirty_d[index] = 1'b0;
      tag_d[index]   = req_tag;
      data_d[index]  = MEM_READDATA;
    end else if (write_en) begin
      dirty_d[index] = 1'b1;
      data_d[index]  = put_byte(data_q[index], offset, WRITEDATA);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data contents are qualified by valid, so they need no reset.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  always_comb begin
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state)
      WRITEBACK: begin
        MEM_ADDRESS   = {tag_q[index], index};
        MEM_WRITEDATA = data_q[index];
      end
      FETCH:   MEM_ADDRESS = {req_tag, index};
      default: ;
    endcase
  end

  assign READDATA = READ ? get_byte(data_q[index], offset) : 8'h00;

endmodule
